encoder_speed_scheduler: RTL and testbench
==========================================

// Module: encoder_speed_scheduler
// PURPOSE
//  Sequences the quadrature-encoder counter blocks of all wheels.
//  - Generates the shared measurement window and the active-low counter-clear strobe (enc_tick).
//  - Snapshots every channel's count and direction at window end.
//  - Streams one signed speed word per channel to the speed controller over a valid/ready handshake.
//  Sits between the per-wheel encoder counters and the PID/odometry logic.
// PARAMETERS
//  NUM_ENC      4   number of encoder channels (1..8)
//  WINDOW_BITS  23  window length = 2**WINDOW_BITS clk cycles (23 -> 167.77 ms @ 50 MHz)
// PORTS
//  clk          in   1          system clock; all logic on rising edge
//  reset_n      in   1          asynchronous active-low reset
//  enable       in   1          1 = windows run; 0 = window counter held at 0, counters held cleared
//  enc_count    in   8*NUM_ENC  channel i count at [8i+7:8i], 0..127 (MSB always 0)
//  enc_dir      in   NUM_ENC    channel i direction; 0 = cw, 1 = ccw
//  enc_tick     out  1          to every counter tick input; 0 clears counters
//  out_valid    out  1          speed word available
//  out_ready    in   1          consumer accepts word when out_valid & out_ready
//  out_id       out  3          channel index of current word
//  out_speed    out  8          signed two's-complement speed, counts per window
//  out_last     out  1          current word is channel NUM_ENC-1
//  overrun      out  1          sticky: a window ended while the previous frame was still pending
//  overrun_cnt  out  8          saturating count of dropped snapshots
// BEHAVIOUR
//  Reset values
//  - All outputs 0 on reset; enc_tick=0, so counters are held cleared during reset.
//  - Reset mid-frame aborts the frame immediately and clears the snapshot.
//  Window counter wcnt
//  - WINDOW_BITS wide; increments every cycle while enable=1.
//  - Wraps from all-ones (WMAX) to 0. Cleared to 0 while enable=0.
//  enc_tick (registered)
//  - 0 during exactly the one cycle with wcnt==0; 1 otherwise, while enable=1.
//  - Held 0 while enable=0.
//  - Encoder edges in the clear cycle are lost by design.
//  Capture
//  - On the edge ending the wcnt==WMAX cycle, all enc_count/enc_dir are registered into the snapshot.
//  - Requires state IDLE; otherwise see overrun.
//  - Counts are taken before the clear lands, so no count is double-counted.
//  Speed arithmetic (per channel)
//  - Speed = dir ? -count : count, width 8 signed, range -127..+127.
//  - count=0 gives 0 regardless of dir. No saturation is needed.
//  FSM
//  - IDLE -> SEND on capture.
//  - SEND: out_valid=1 from the cycle after capture; out_id starts at 0.
//  - out_id/out_speed/out_last stay stable until the handshake completes.
//  - On each handshake out_id++. A handshake at out_id==NUM_ENC-1 -> IDLE and out_valid=0 the next cycle.
//  - Zero-bubble: back-to-back words when out_ready is held 1, so NUM_ENC cycles per frame.
//  - enable falling during SEND does not abort; the frame finishes.
//  Overrun
//  - A window end while in SEND keeps the current frame and discards the new snapshot.
//  - Sets overrun=1 (cleared only by reset); overrun_cnt++ saturating at 255.
//  - Windows and clears continue regardless of a stalled consumer.
// CONFIGURATION
//  ODOMETRY_EN defined
//  - Adds port odo_pos  out  24*NUM_ENC: per-channel signed position.
//  - At each accepted capture, pos_i <= pos_i + speed_i, two's-complement wrap, reset 0.
//  - Dropped (overrun) snapshots do not update pos.
//  ODOMETRY_EN undefined
//  - Port and accumulators absent; all other behaviour identical.
// TESTING (sim with WINDOW_BITS=4, NUM_ENC=4)
//  1 Reset with enable=1
//    -> enc_tick=0 in reset; after release enc_tick low 1 cycle every 16 cycles, at wcnt==0.
//  2 Counts {10,0,127,5}, dirs {0,1,1,1}, out_ready=1
//    -> words id0..3 = +10, 0, -127, -5 on 4 consecutive cycles; out_last only on id3.
//  3 out_ready=0 for 3 cycles at id1
//    -> id1 word held stable; frame resumes at id1 with no loss or duplication.
//  4 out_ready=0 for 40 cycles
//    -> overrun=1, overrun_cnt=2; the frame delivered is the first snapshot.
//  5 enable=0 mid-window, then enable=1
//    -> enc_tick=0 while disabled; next capture exactly 16 cycles after re-enable.
//  6 ODOMETRY_EN, ch0 speed +100 for 3 windows then -30 once
//    -> odo_pos ch0 = 270; pos at 0x7FFFF0 + 0x20 wraps to 0x800010.

Source files
------------

// File: rtl/encoder_speed_scheduler.sv
// encoder_speed_scheduler
//   Generates the shared measurement window for all wheel encoder counters,
//   pulses the active-low counter clear (enc_tick), snapshots every channel
//   at window end and streams one signed speed word per channel over a
//   valid/ready handshake.
//   Optional feature: define ODOMETRY_EN to add per-channel 24-bit position
//   accumulators on port odo_pos.
module encoder_speed_scheduler #(
  parameter int NUM_ENC     = 4,
  parameter int WINDOW_BITS = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [8*NUM_ENC-1:0]   enc_count,
  input  logic [NUM_ENC-1:0]     enc_dir,
  output logic                   enc_tick,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_id,
  output logic [7:0]             out_speed,
  output logic                   out_last,
  output logic                   overrun,
  output logic [7:0]             overrun_cnt
`ifdef ODOMETRY_EN
  ,
  output logic [24*NUM_ENC-1:0]  odo_pos
`endif
);

  localparam logic [WINDOW_BITS-1:0] WMAX    = '1;
  localparam logic [WINDOW_BITS-1:0] WONE    = WINDOW_BITS'(1);
  localparam logic [2:0]             LAST_ID = 3'(NUM_ENC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [WINDOW_BITS-1:0] wcnt_reg;
  logic                   window_end;
  logic                   capture;
  logic                   handshake;
  logic [2:0]             id_next;
  logic [7:0]             speed_next;
  logic [7:0]             speed_in       [NUM_ENC];
  logic [7:0]             snap_speed_reg [NUM_ENC];

  // The last cycle of a window; the clear lands one cycle later, so counts
  // sampled here are complete and never counted twice.
  assign window_end = (wcnt_reg == WMAX);
  assign capture    = window_end && (state_reg == IDLE);
  assign handshake  = out_valid && out_ready;
  assign id_next    = out_id + 3'd1;

  // Per-channel signed speed straight from the counter inputs.
  // Counts never exceed 127, so negation cannot overflow.
  generate
    for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_speed
      logic [7:0] cnt;
      assign cnt          = enc_count[8*gi +: 8];
      assign speed_in[gi] = enc_dir[gi] ? (8'd0 - cnt) : cnt;
    end
  endgenerate

  // Select the snapshot word for the channel that follows the current one.
  always_comb begin
    speed_next = 8'd0;
    for (int i = 0; i < NUM_ENC; i++) begin
      if (id_next == 3'(i)) speed_next = snap_speed_reg[i];
    end
  end

  // Window counter and registered clear strobe: enc_tick is low exactly in
  // the cycle where wcnt is 0, and held low while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_reg <= '0;
      enc_tick <= 1'b0;
    end else if (!enable) begin
      wcnt_reg <= '0;
      enc_tick <= 1'b0;
    end else begin
      wcnt_reg <= wcnt_reg + WONE;
      enc_tick <= (wcnt_reg != WMAX);
    end
  end

  // Frame FSM: capture snapshot in IDLE, stream words in SEND, and count
  // window ends that arrive while a frame is still pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      out_valid   <= 1'b0;
      out_id      <= 3'd0;
      out_speed   <= 8'd0;
      out_last    <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
      for (int i = 0; i < NUM_ENC; i++) snap_speed_reg[i] <= 8'd0;
    end else begin
      if ((state_reg == SEND) && handshake) begin
        if (out_last) begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
        end else begin
          out_id    <= id_next;
          out_speed <= speed_next;
          out_last  <= (id_next == LAST_ID);
        end
      end
      if (capture) begin
        for (int i = 0; i < NUM_ENC; i++) snap_speed_reg[i] <= speed_in[i];
        state_reg <= SEND;
        out_valid <= 1'b1;
        out_id    <= 3'd0;
        out_speed <= speed_in[0];
        out_last  <= (LAST_ID == 3'd0);
      end else if (window_end) begin
        // Current frame is kept; the new snapshot is dropped.
        overrun <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

`ifdef ODOMETRY_EN
  logic [23:0] pos_reg [NUM_ENC];

  generate
    for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_odo
      assign odo_pos[24*gi +: 24] = pos_reg[gi];

      // Accumulate position only on accepted captures; wraps naturally.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pos_reg[gi] <= 24'd0;
        end else if (capture) begin
          pos_reg[gi] <= pos_reg[gi] + {{16{speed_in[gi][7]}}, speed_in[gi]};
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_encoder_speed_scheduler.sv
// Directed self-checking bench for encoder_speed_scheduler
// (WINDOW_BITS=4, NUM_ENC=4). Define ODOMETRY_EN to also exercise odo_pos.
module tb_encoder_speed_scheduler;

  localparam int NUM_ENC     = 4;
  localparam int WINDOW_BITS = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic [8*NUM_ENC-1:0] enc_count;
  logic [NUM_ENC-1:0]   enc_dir;
  logic                 enc_tick;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_id;
  logic [7:0]           out_speed;
  logic                 out_last;
  logic                 overrun;
  logic [7:0]           overrun_cnt;
`ifdef ODOMETRY_EN
  logic [24*NUM_ENC-1:0] odo_pos;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_speed_scheduler #(
    .NUM_ENC     (NUM_ENC),
    .WINDOW_BITS (WINDOW_BITS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .enc_count   (enc_count),
    .enc_dir     (enc_dir),
    .enc_tick    (enc_tick),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_speed   (out_speed),
    .out_last    (out_last),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
`ifdef ODOMETRY_EN
    ,
    .odo_pos     (odo_pos)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Wait for enc_tick low, returning the number of negedges waited.
  task automatic wait_tick_low(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (enc_tick !== 1'b0 && n < 40);
    if (n >= 40) check("tick_timeout", 32'd0, 32'd1);
  endtask

  // Wait for a rising edge of out_valid (a new capture).
  task automatic wait_capture();
    logic prev;
    int   n;
    prev = out_valid;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1 && prev === 1'b0) break;
      prev = out_valid;
    end while (n < 60);
    if (n >= 60) check("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_word(input string tag, input int id, input logic [7:0] spd, input logic last);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_id"},    32'(out_id),    32'(id));
    check({tag, "_speed"}, 32'(out_speed), 32'(spd));
    check({tag, "_last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    // ch0=10 cw, ch1=0 ccw, ch2=127 ccw, ch3=5 ccw
    enc_count = {8'd5, 8'd127, 8'd0, 8'd10};
    enc_dir   = 4'b1110;

    // ---- 1: reset state and tick period ----
    repeat (3) @(negedge clk);
    check("rst_tick",    32'(enc_tick),    32'd0);
    check("rst_valid",   32'(out_valid),   32'd0);
    check("rst_id",      32'(out_id),      32'd0);
    check("rst_speed",   32'(out_speed),   32'd0);
    check("rst_overrun", 32'(overrun),     32'd0);
    check("rst_ovcnt",   32'(overrun_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("tick_after_rel", 32'(enc_tick), 32'd1);
    wait_tick_low(n);
    check("tick_first_gap", 32'(n), 32'd15);
    wait_tick_low(n);
    check("tick_period", 32'(n), 32'd16);
    @(negedge clk);
    check("tick_one_cycle", 32'(enc_tick), 32'd1);

    // ---- 2: zero-bubble frame ----
    wait_capture();
    check_word("t2_w0", 0, 8'd10, 1'b0);
    @(negedge clk); check_word("t2_w1", 1, 8'd0,  1'b0);
    @(negedge clk); check_word("t2_w2", 2, 8'h81, 1'b0);
    @(negedge clk); check_word("t2_w3", 3, 8'hFB, 1'b1);
    @(negedge clk); check("t2_done_valid", 32'(out_valid), 32'd0);

    // ---- 3: stall at id1 ----
    wait_capture();
    check_word("t3_w0", 0, 8'd10, 1'b0);
    @(negedge clk);
    check_word("t3_w1", 1, 8'd0, 1'b0);
    out_ready = 1'b0;
    enc_count = {8'd50, 8'd40, 8'd30, 8'd20};   // must not disturb the snapshot
    enc_dir   = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_word("t3_hold", 1, 8'd0, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk); check_word("t3_w2", 2, 8'h81, 1'b0);
    @(negedge clk); check_word("t3_w3", 3, 8'hFB, 1'b1);
    @(negedge clk); check("t3_done_valid", 32'(out_valid), 32'd0);
    check("t3_no_overrun", 32'(overrun), 32'd0);

    // ---- 4: long stall -> two dropped snapshots ----
    wait_capture();
    out_ready = 1'b0;
    enc_count = {8'd4, 8'd3, 8'd2, 8'd1};
    enc_dir   = 4'b1111;
    repeat (40) @(negedge clk);
    check("t4_overrun", 32'(overrun),     32'd1);
    check("t4_ovcnt",   32'(overrun_cnt), 32'd2);
    check_word("t4_w0_held", 0, 8'd20, 1'b0);
    out_ready = 1'b1;
    @(negedge clk); check_word("t4_w1", 1, 8'd30, 1'b0);
    @(negedge clk); check_word("t4_w2", 2, 8'd40, 1'b0);
    @(negedge clk); check_word("t4_w3", 3, 8'd50, 1'b1);
    @(negedge clk); check("t4_done_valid", 32'(out_valid), 32'd0);

    // ---- 5: disable mid-window, re-enable ----
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t5_tick_dis", 32'(enc_tick), 32'd0);
    end
    check("t5_no_capture", 32'(out_valid), 32'd0);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 40);
    check("t5_capture_delay", 32'(n), 32'd16);
    check("t5_tick_at_cap", 32'(enc_tick), 32'd0);
    check_word("t5_w0", 0, 8'hFF, 1'b0);
    check("t5_overrun_sticky", 32'(overrun), 32'd1);

`ifdef ODOMETRY_EN
    // ---- 6: odometry accumulation and wrap ----
    @(negedge clk);
    reset_n = 1'b0;
    enc_count = {8'd0, 8'd0, 8'd127, 8'd100};
    enc_dir   = 4'b0010;
    @(negedge clk);
    check("t6_rst_pos", 32'(odo_pos[23:0]), 32'd0);
    reset_n = 1'b1;
    wait_capture();
    wait_capture();
    wait_capture();
    check("t6_pos0_300", 32'(odo_pos[23:0]), 32'd300);
    enc_count[7:0] = 8'd30;
    enc_dir[0]     = 1'b1;
    wait_capture();
    check("t6_pos0_270", 32'(odo_pos[23:0]),  32'd270);
    check("t6_pos1_wrap", 32'(odo_pos[47:24]), 32'hFFFE04);   // -4*127
    check("t6_pos2_zero", 32'(odo_pos[71:48]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
